// File: rtl/vr_pack.sv
// vr_pack: valid/ready width upsizer.
// Packs RATIO WIDTH-bit words, little-endian, into one wide word.
module vr_pack #(
  parameter int WIDTH = 16,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_rdy,
  output logic                   out_valid,
  output logic [RATIO*WIDTH-1:0] out_data,
  input  logic                   out_rdy
);

  if (RATIO < 2) begin : g_bad_ratio
    $error("vr_pack: RATIO must be >= 2");
  end

  localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic                       run;
  logic [CW-1:0]              count;
  logic [(RATIO-1)*WIDTH-1:0] acc;
  logic                       in_xfer;
  logic                       out_xfer;

  // Ready depends on registers only, never on out_rdy.
  assign in_rdy   = run && !(count == LAST && out_valid);
  assign in_xfer  = in_valid && in_rdy;
  assign out_xfer = out_valid && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      run <= 1'b1;
      if (out_xfer)
        out_valid <= 1'b0;
      if (in_xfer) begin
        if (count == LAST) begin
          out_data  <= {in_data, acc};
          out_valid <= 1'b1;
          count     <= '0;
        end else begin
          for (int i = 0; i < RATIO - 1; i++)
            if (count == CW'(i))
              acc[i*WIDTH +: WIDTH] <= in_data;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vr_pack.sv
// tb_vr_pack: random and directed checks of vr_pack
// against a queue-based packing model.
module tb_vr_pack;

  localparam int W = 8;
  localparam int R = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_rdy;
  logic           out_valid;
  logic [R*W-1:0] out_data;
  logic           out_rdy = 1'b0;

  vr_pack #(.WIDTH(W), .RATIO(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_rdy  (out_rdy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0]   part[$];
  logic           run_m;
  logic           have_out;
  logic [R*W-1:0] out_exp;
  logic           last_acc;
  int             n_acc;
  int             n_out;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic exp_rdy();
    return run_m && !(part.size() == R - 1 && have_out);
  endfunction

  // One cycle: drive, compare, step the model across the edge.
  task automatic cyc(input logic v, input logic [W-1:0] d,
                     input logic r);
    logic ix, ox;
    logic [R*W-1:0] w;
    in_valid = v;
    in_data  = d;
    out_rdy  = r;
    check("in_rdy", in_rdy, exp_rdy());
    check("out_valid", out_valid, have_out);
    if (have_out) check("out_data", out_data, out_exp);
    ix = v && exp_rdy();
    ox = have_out && r;
    @(posedge clk);
    if (ox) begin
      have_out = 1'b0;
      n_out++;
    end
    if (ix) begin
      n_acc++;
      part.push_back(d);
      if (part.size() == R) begin
        w = '0;
        for (int k = 0; k < R; k++) w[k*W +: W] = part[k];
        out_exp  = w;
        have_out = 1'b1;
        part.delete();
      end
    end
    last_acc = ix;
    run_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    part.delete();
    have_out = 1'b0;
    run_m = 1'b0;
    #1;
    check("rst_in_rdy", in_rdy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_rdy", in_rdy, 1'b0);
    rst_n = 1'b1;
  endtask

  // Offer a word until accepted, with a cycle bound.
  task automatic send(input logic [W-1:0] d, input logic r);
    int t = 0;
    do begin
      cyc(1'b1, d, r);
      t++;
    end while (!last_acc && t < 50);
    if (!last_acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  logic [W-1:0] cur;
  logic         v;
  int           cycles;

  initial begin
    run_m = 1'b0; have_out = 1'b0; out_exp = '0;
    last_acc = 1'b0; n_acc = 0; n_out = 0;
    #2;
    do_reset();

    // release: in_rdy low on first edge, then high
    cyc(1'b0, 8'h00, 1'b1);
    check("run_up", in_rdy, 1'b1);

    // basic pack
    foreach (cur[i]) ;
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    send(8'h33, 1'b1); send(8'h44, 1'b1);
    check("pk1_valid", out_valid, 1'b1);
    check("pk1_data", out_data, 32'h44332211);
    cyc(1'b0, 8'h00, 1'b1);
    check("pk1_drop", out_valid, 1'b0);

    // continuous stream, no bubbles
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      check("stream_acc", last_acc, 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    check("stream_nout", n_out, 4);

    // stall with out_rdy low
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    cyc(1'b1, 8'h88, 1'b0);
    check("stall_blk", last_acc, 1'b0);
    cyc(1'b1, 8'h88, 1'b0);
    check("stall_data", out_data, 32'h44332211);
    cyc(1'b1, 8'h88, 1'b1);
    check("stall_rel", last_acc, 1'b0);
    cyc(1'b1, 8'h88, 1'b1);
    check("stall_4th", last_acc, 1'b1);
    check("stall_pk", out_data, 32'h88776655);
    cyc(1'b0, 8'h00, 1'b1);

    // random traffic
    n_acc = 0; n_out = 0; cycles = 0;
    cur = 8'($urandom); v = 1'b0;
    while (n_acc < 1000 && cycles < 20000) begin
      if (!v) begin
        v = 1'($urandom_range(0, 1));
        cur = 8'($urandom);
      end
      cyc(v, cur, 1'($urandom_range(0, 1)));
      if (last_acc) v = 1'b0;
      cycles++;
    end
    check("rnd_words", n_acc, 1000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    check("rnd_outs", n_out, 250);

    // reset mid-stream
    send(8'h5A, 1'b1); send(8'h5B, 1'b1);
    do_reset();
    cyc(1'b0, 8'h00, 1'b1);
    send(8'hA1, 1'b1); send(8'hA2, 1'b1);
    send(8'hA3, 1'b1); send(8'hA4, 1'b1);
    check("rst_pk", out_data, 32'hA4A3A2A1);
    cyc(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
